regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised successor to the core's integer register file.
- Adds a configurable number of read ports and a per-register outstanding-writer scoreboard.
- The decode stage reads operands and gets hazard flags. It reserves destinations at issue; writeback releases them.
- Sits between ID (read/issue) and WB (write) in the pipeline.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 4, register address width
NUM_REGS, 15, implemented registers (addresses 0..NUM_REGS-1; must be <= 2**ADDR_W)
NUM_RD, 3, number of read ports
CNT_W, 2, width of each per-register outstanding-writer counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, combinational, port k at [k*DATA_W +: DATA_W]
rd_hazard  out  NUM_RD  1 = port k's register has an outstanding writer
iss_en  in  1  reserve destination iss_addr this cycle
iss_addr  in  ADDR_W  destination being issued
iss_stall  out  1  combinational; iss_en requested on a register whose counter is saturated
wb_en  in  1  writeback valid
wb_addr  in  ADDR_W  writeback destination
wb_data  in  DATA_W  writeback value
busy_vec  out  NUM_REGS  bit r = counter[r] != 0
sb_err  out  1  sticky underflow error flag

Behaviour:
- Reset (rst=1 at rising edge):
  - all registers <= 0, all counters <= 0, sb_err <= 0.
  - Outputs after reset: rd_data=0, rd_hazard=0, busy_vec=0, iss_stall=0.
  - Reset overrides wb/iss in the same cycle.
- Write:
  - wb_en=1 and wb_addr < NUM_REGS: reg[wb_addr] <= wb_data at the rising edge.
  - Addresses >= NUM_REGS are ignored, and the counter is untouched.
- Read:
  - Combinational.
  - rd_addr >= NUM_REGS returns 0 with hazard 0.
  - Same-cycle write-to-read behaviour is set by the optional feature.
- Scoreboard, counter r, per edge:
  - inc = iss_en && iss_addr==r && !iss_stall.
  - dec = wb_en && wb_addr==r.
  - inc&&!dec: +1. dec&&!inc: -1. Both: unchanged. Neither: unchanged.
- iss_stall = iss_en && iss_addr<NUM_REGS && counter[iss_addr]==2**CNT_W-1 && !(wb_en && wb_addr==iss_addr).
  - A simultaneous release un-stalls the issue.
- Underflow: dec with counter==0 leaves the counter at 0 and sets sb_err=1, which stays set until reset.
- iss_en with iss_addr >= NUM_REGS has no effect and iss_stall=0.
- rd_hazard[k] = (counter[rd_addr_k] != 0), subject to the bypass rule below.
- Latency:
  - A write is visible on rd_data in the next cycle, or the same cycle with bypass.
  - An issue reservation is visible on rd_hazard and busy_vec the next cycle.

Optional Feature:
REGFILE_WB_BYPASS_EN
- Defined:
  - A read port whose address equals wb_addr while wb_en=1 returns wb_data in the same cycle.
  - Its rd_hazard is forced 0 when the counter for that register is exactly 1, since the last writer is completing.
- Undefined:
  - The read returns the stored (old) value.
  - rd_hazard reflects the counter only.
  - The core must then stall one extra cycle after writeback.

Decomposition:
- Shared package regfile_pkg holds:
  - constants DATA_W_DEF=32, ADDR_W_DEF=4, NUM_REGS_DEF=15 (R15 = PC lives elsewhere);
  - a function to extract port k's slice from the packed address and data buses.
- One natural sub-module, sb_counter: one saturating up/down counter with inc, dec, sat, zero and underflow outputs, instantiated NUM_REGS times by generate.
- The storage array and read muxes stay in the top.

Test Plan:
1. Reset: write 0xDEADBEEF to r3, then rst=1 for one cycle -> rd_data(r3)=0, busy_vec=0, sb_err=0.
2. Write/read: wb r5=0x12345678.
   - Same-cycle read of r5 returns old 0 without bypass, 0x12345678 with bypass.
   - Next cycle returns 0x12345678 on all NUM_RD ports.
3. Scoreboard: iss r2 -> next cycle rd_hazard=1 on a port reading r2 and busy_vec[2]=1; wb r2 -> counter 0 and hazard 0 the cycle after.
4. Saturation with CNT_W=2:
   - Three issues to r7 -> counter 3; a fourth iss_en -> iss_stall=1 and counter stays 3.
   - Same cycle iss+wb on r7 -> iss_stall=0, counter stays 3.
5. Underflow: wb r9 with counter 0 -> sb_err=1, counter 0, data written; sb_err holds until rst.
6. Out of range: wb/iss/read address 15 with NUM_REGS=15 -> no state change, rd_data=0, rd_hazard=0, iss_stall=0.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared constants and bus-slicing helper for the register file
//            with outstanding-writer scoreboard.
// Contents : DATA_W_DEF, ADDR_W_DEF, NUM_REGS_DEF (R15 = PC lives elsewhere),
//            NUM_RD_DEF, CNT_W_DEF, bus_slice() helper.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

   localparam int DATA_W_DEF   = 32;
   localparam int ADDR_W_DEF   = 4;
   localparam int NUM_REGS_DEF = 15;
   localparam int NUM_RD_DEF   = 3;
   localparam int CNT_W_DEF    = 2;

   // Widest packed bus bus_slice() can handle; callers zero-extend into it.
   localparam int SLICE_BUS_W  = 512;

   // Returns field k of width w from a packed bus, right-justified.
   function automatic logic [SLICE_BUS_W-1:0] bus_slice(
      input logic [SLICE_BUS_W-1:0] i_bus,
      input int unsigned            i_k,
      input int unsigned            i_w
   );
      logic [SLICE_BUS_W-1:0] w_mask;
      w_mask = '1;
      w_mask = w_mask >> (SLICE_BUS_W - i_w);
      return (i_bus >> (i_k * i_w)) & w_mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard_if
// Purpose  : Read / issue / writeback bus of the scoreboarded register file.
// Ports    : master = ID/WB pipeline side (drives addresses, issue, writeback)
//            slave  = register file (returns data, hazards, stall, status)
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_scoreboard_if
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int NUM_RD   = NUM_RD_DEF
);
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_hazard;
   logic                     iss_en;
   logic [ADDR_W-1:0]        iss_addr;
   logic                     iss_stall;
   logic                     wb_en;
   logic [ADDR_W-1:0]        wb_addr;
   logic [DATA_W-1:0]        wb_data;
   logic [NUM_REGS-1:0]      busy_vec;
   logic                     sb_err;

   modport master (
      output rd_addr, iss_en, iss_addr, wb_en, wb_addr, wb_data,
      input  rd_data, rd_hazard, iss_stall, busy_vec, sb_err
   );

   modport slave (
      input  rd_addr, iss_en, iss_addr, wb_en, wb_addr, wb_data,
      output rd_data, rd_hazard, iss_stall, busy_vec, sb_err
   );
endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard_sb_counter.sv
`default_nettype none
// ============================================================================
// Module   : sb_counter
// Purpose  : Saturating up/down outstanding-writer counter for one register.
// Ports    : clk, rst (sync, active-high)
//            i_inc / i_dec  reserve / release one writer
//            o_cnt          current count
//            o_sat          count is at its maximum
//            o_zero         no outstanding writer
//            o_underflow    release requested with no writer outstanding
// Revision : 1.0 - initial release
// ============================================================================
module sb_counter #(
   parameter int CNT_W = 2
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_sat,
   output logic             o_zero,
   output logic             o_underflow
);
   logic [CNT_W-1:0] r_cnt;

   assign o_cnt       = r_cnt;
   assign o_zero      = (r_cnt == '0);
   assign o_sat       = (r_cnt == '1);
   // Any release against an empty counter is flagged, even when an issue
   // lands on the same register in the same cycle.
   assign o_underflow = i_dec && o_zero;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_inc && !i_dec && !o_sat) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else if (i_dec && !i_inc && !o_zero) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end
endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Integer register file with NUM_RD combinational read ports and a
//            per-register outstanding-writer scoreboard (reserve at issue,
//            release at writeback).
// Ports    : clk, rst (sync, active-high)
//            bus (regfile_scoreboard_if.slave):
//              rd_addr/rd_data/rd_hazard  read ports with hazard flags
//              iss_en/iss_addr/iss_stall  destination reservation
//              wb_en/wb_addr/wb_data      writeback (also releases)
//              busy_vec                   per-register "writer outstanding"
//              sb_err                     sticky underflow flag
// Options  : REGFILE_WB_BYPASS_EN - forward same-cycle writeback data to the
//            read ports and drop the hazard of a completing last writer.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int NUM_RD   = NUM_RD_DEF,
   parameter int CNT_W    = CNT_W_DEF
)(
   input  logic                 clk,
   input  logic                 rst,
   regfile_scoreboard_if.slave  bus
);
   logic [DATA_W-1:0]      r_regs [NUM_REGS];
   logic [CNT_W-1:0]       w_cnt  [NUM_REGS];
   logic [NUM_REGS-1:0]    w_sat;
   logic [NUM_REGS-1:0]    w_zero;
   logic [NUM_REGS-1:0]    w_underflow;
   logic [NUM_REGS-1:0]    w_inc;
   logic [NUM_REGS-1:0]    w_dec;
   logic                   w_iss_sat;
   logic                   w_iss_stall;
   logic                   r_sb_err;
   logic [SLICE_BUS_W-1:0] w_addr_bus;

   // Out-of-range issue addresses match no register, so they never stall.
   always_comb begin
      w_iss_sat = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (bus.iss_addr == ADDR_W'(r) && w_sat[r]) begin
            w_iss_sat = 1'b1;
         end
      end
   end

   // A release to the same register frees a slot in the same edge.
   assign w_iss_stall = bus.iss_en && w_iss_sat &&
                        !(bus.wb_en && bus.wb_addr == bus.iss_addr);

   generate
      for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
         assign w_inc[r] = bus.iss_en && !w_iss_stall &&
                           (bus.iss_addr == ADDR_W'(r));
         assign w_dec[r] = bus.wb_en && (bus.wb_addr == ADDR_W'(r));

         sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk         (clk),
            .rst         (rst),
            .i_inc       (w_inc[r]),
            .i_dec       (w_dec[r]),
            .o_cnt       (w_cnt[r]),
            .o_sat       (w_sat[r]),
            .o_zero      (w_zero[r]),
            .o_underflow (w_underflow[r])
         );
      end
   endgenerate

   // w_dec doubles as the in-range write decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            r_regs[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (w_dec[r]) begin
               r_regs[r] <= bus.wb_data;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sb_err <= 1'b0;
      end else if (|w_underflow) begin
         r_sb_err <= 1'b1;
      end
   end

   assign bus.iss_stall = w_iss_stall;
   assign bus.busy_vec  = ~w_zero;
   assign bus.sb_err    = r_sb_err;

   assign w_addr_bus = SLICE_BUS_W'(bus.rd_addr);

   generate
      for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
         logic [ADDR_W-1:0] w_addr;
         logic [DATA_W-1:0] w_data;
         logic              w_haz;
`ifdef REGFILE_WB_BYPASS_EN
         logic              w_hit;
         logic              w_one;
`endif

         assign w_addr = ADDR_W'(bus_slice(w_addr_bus, k, ADDR_W));

         // Addresses with no matching register fall through to 0 / no hazard.
         always_comb begin
            w_data = '0;
            w_haz  = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
            w_hit  = 1'b0;
            w_one  = 1'b0;
`endif
            for (int r = 0; r < NUM_REGS; r++) begin
               if (w_addr == ADDR_W'(r)) begin
                  w_data = r_regs[r];
                  w_haz  = (w_cnt[r] != '0);
`ifdef REGFILE_WB_BYPASS_EN
                  w_hit  = 1'b1;
                  w_one  = (w_cnt[r] == CNT_W'(1));
`endif
               end
            end
`ifdef REGFILE_WB_BYPASS_EN
            // Forward the completing write; if it is the last writer the
            // operand is final this cycle.
            if (w_hit && bus.wb_en && bus.wb_addr == w_addr) begin
               w_data = bus.wb_data;
               if (w_one) begin
                  w_haz = 1'b0;
               end
            end
`endif
         end

         assign bus.rd_data[k*DATA_W +: DATA_W] = w_data;
         assign bus.rd_hazard[k]                = w_haz;
      end
   endgenerate
endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Purpose  : Directed, table-driven self-checking bench for regfile_scoreboard
//            (default parameters). Expected values follow the build option
//            REGFILE_WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;
`ifdef REGFILE_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam logic [31:0] D = 32'hDEADBEEF;
   localparam logic [31:0] P = 32'h12345678;
   localparam logic [31:0] Q = 32'hA5A5A5A5;

   typedef struct {
      logic        rst;
      logic        ie;
      logic [3:0]  ia;
      logic        we;
      logic [3:0]  wa;
      logic [31:0] wd;
      logic [3:0]  a0, a1, a2;
      logic [31:0] d0, d1, d2;
      logic [2:0]  h;
      logic        s;
      logic [14:0] b;
      logic        e;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t tbl [30];

   always #5 clk = ~clk;

   regfile_scoreboard_if u_bus ();

   regfile_scoreboard u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_bus)
   );

   function automatic vec_t mk(
      input logic r, input logic ie, input logic [3:0] ia,
      input logic we, input logic [3:0] wa, input logic [31:0] wd,
      input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
      input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
      input logic [2:0] h, input logic s, input logic [14:0] b, input logic e
   );
      vec_t v;
      v.rst = r;  v.ie = ie; v.ia = ia; v.we = we; v.wa = wa; v.wd = wd;
      v.a0 = a0;  v.a1 = a1; v.a2 = a2; v.d0 = d0; v.d1 = d1; v.d2 = d2;
      v.h = h;    v.s = s;   v.b = b;   v.e = e;
      return v;
   endfunction

   function automatic logic [31:0] by(input logic [31:0] a, input logic [31:0] b);
      return BYP ? a : b;
   endfunction

   task automatic chk(input string nm, input int idx,
                      input logic [95:0] act, input logic [95:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic ie, input logic [3:0] ia,
                        input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
      rst            = r;
      u_bus.iss_en   = ie;
      u_bus.iss_addr = ia;
      u_bus.wb_en    = we;
      u_bus.wb_addr  = wa;
      u_bus.wb_data  = wd;
      u_bus.rd_addr  = {a2, a1, a0};
   endtask

   initial begin
      // rst ie ia  we wa  wd            a0 a1 a2  d0..d2                          h  s  busy    e
      tbl[0]  = mk(0,0,0, 1,3, D,            3,3,3,  by(D,0),by(D,0),by(D,0),       3'b000,0,15'h0,0);
      tbl[1]  = mk(1,1,4, 1,4, 32'h1111,     3,3,3,  D,D,D,                         3'b000,0,15'h0,1);
      tbl[2]  = mk(0,0,0, 0,0, 0,            3,4,3,  0,0,0,                         3'b000,0,15'h0,0);
      tbl[3]  = mk(0,1,5, 0,0, 0,            0,0,0,  0,0,0,                         3'b000,0,15'h0,0);
      tbl[4]  = mk(0,0,0, 1,5, P,            5,5,5,  by(P,0),by(P,0),by(P,0),       BYP?3'b000:3'b111,0,15'h20,0);
      tbl[5]  = mk(0,0,0, 0,0, 0,            5,5,5,  P,P,P,                         3'b000,0,15'h0,0);
      tbl[6]  = mk(0,1,2, 0,0, 0,            2,5,0,  0,P,0,                         3'b000,0,15'h0,0);
      tbl[7]  = mk(0,0,0, 0,0, 0,            2,5,0,  0,P,0,                         3'b001,0,15'h4,0);
      tbl[8]  = mk(0,0,0, 1,2, Q,            2,2,5,  by(Q,0),by(Q,0),P,             BYP?3'b000:3'b011,0,15'h4,0);
      tbl[9]  = mk(0,0,0, 0,0, 0,            2,5,2,  Q,P,Q,                         3'b000,0,15'h0,0);
      tbl[10] = mk(0,1,7, 0,0, 0,            7,0,0,  0,0,0,                         3'b000,0,15'h0,0);
      tbl[11] = mk(0,1,7, 0,0, 0,            7,0,0,  0,0,0,                         3'b001,0,15'h80,0);
      tbl[12] = mk(0,1,7, 0,0, 0,            7,0,0,  0,0,0,                         3'b001,0,15'h80,0);
      tbl[13] = mk(0,1,7, 0,0, 0,            7,0,0,  0,0,0,                         3'b001,1,15'h80,0);
      tbl[14] = mk(0,1,7, 1,7, 32'h77,       7,7,7,  by(32'h77,0),by(32'h77,0),by(32'h77,0), 3'b111,0,15'h80,0);
      tbl[15] = mk(0,1,7, 0,0, 0,            7,7,7,  32'h77,32'h77,32'h77,          3'b111,1,15'h80,0);
      tbl[16] = mk(0,0,0, 1,7, 32'h71,       7,0,0,  by(32'h71,32'h77),0,0,         3'b001,0,15'h80,0);
      tbl[17] = mk(0,0,0, 1,7, 32'h72,       7,0,0,  by(32'h72,32'h71),0,0,         3'b001,0,15'h80,0);
      tbl[18] = mk(0,0,0, 1,7, 32'h73,       7,0,0,  by(32'h73,32'h72),0,0,         BYP?3'b000:3'b001,0,15'h80,0);
      tbl[19] = mk(0,0,0, 0,0, 0,            7,0,0,  32'h73,0,0,                    3'b000,0,15'h0,0);
      tbl[20] = mk(0,0,0, 1,9, 32'h99,       9,0,0,  by(32'h99,0),0,0,              3'b000,0,15'h0,0);
      tbl[21] = mk(0,0,0, 0,0, 0,            9,0,0,  32'h99,0,0,                    3'b000,0,15'h0,1);
      tbl[22] = mk(0,1,9, 0,0, 0,            9,0,0,  32'h99,0,0,                    3'b000,0,15'h0,1);
      tbl[23] = mk(0,0,0, 0,0, 0,            9,0,0,  32'h99,0,0,                    3'b001,0,15'h200,1);
      tbl[24] = mk(0,0,0, 1,9, 32'h9A,       9,0,0,  by(32'h9A,32'h99),0,0,         BYP?3'b000:3'b001,0,15'h200,1);
      tbl[25] = mk(0,0,0, 0,0, 0,            9,0,0,  32'h9A,0,0,                    3'b000,0,15'h0,1);
      tbl[26] = mk(0,1,15,1,15,32'hFFFFFFFF, 15,15,0, 0,0,0,                        3'b000,0,15'h0,1);
      tbl[27] = mk(0,0,0, 0,0, 0,            15,9,2, 0,32'h9A,Q,                    3'b000,0,15'h0,1);
      tbl[28] = mk(1,0,0, 0,0, 0,            9,0,0,  32'h9A,0,0,                    3'b000,0,15'h0,1);
      tbl[29] = mk(0,0,0, 0,0, 0,            9,0,0,  0,0,0,                         3'b000,0,15'h0,0);

      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);

      for (int i = 0; i < 30; i++) begin
         #1;
         drive(tbl[i].rst, tbl[i].ie, tbl[i].ia, tbl[i].we, tbl[i].wa, tbl[i].wd,
               tbl[i].a0, tbl[i].a1, tbl[i].a2);
         @(negedge clk);
         chk("rd_data",   i, 96'(u_bus.rd_data),   {tbl[i].d2, tbl[i].d1, tbl[i].d0});
         chk("rd_hazard", i, 96'(u_bus.rd_hazard), 96'(tbl[i].h));
         chk("iss_stall", i, 96'(u_bus.iss_stall), 96'(tbl[i].s));
         chk("busy_vec",  i, 96'(u_bus.busy_vec),  96'(tbl[i].b));
         chk("sb_err",    i, 96'(u_bus.sb_err),    96'(tbl[i].e));
         @(posedge clk);
      end

      // Fill r1 to saturation, confirm the fourth issue stalls, then drain.
      for (int i = 0; i < 4; i++) begin
         #1;
         drive(0, 1, 1, 0, 0, 0, 1, 1, 1);
         @(negedge clk);
         chk("sat_stall", 100 + i, 96'(u_bus.iss_stall), 96'(i == 3));
         chk("sat_busy",  100 + i, 96'(u_bus.busy_vec),  (i == 0) ? 96'h0 : 96'h2);
         @(posedge clk);
      end
      for (int i = 0; i < 3; i++) begin
         #1;
         drive(0, 0, 0, 1, 1, 32'h100 + 32'(i), 1, 1, 1);
         @(negedge clk);
         chk("drain_busy", 110 + i, 96'(u_bus.busy_vec), 96'h2);
         @(posedge clk);
      end
      #1;
      drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
      @(negedge clk);
      chk("drain_done_busy", 120, 96'(u_bus.busy_vec),  96'h0);
      chk("drain_done_haz",  120, 96'(u_bus.rd_hazard), 96'h0);
      chk("drain_done_err",  120, 96'(u_bus.sb_err),    96'h0);
      chk("drain_done_data", 120, 96'(u_bus.rd_data),   {3{32'h102}});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
